instr_fetch: RTL and testbench

Two-byte instruction fetch stage for the 8-bit CPU. It sits between the instruction ROM and the Controller/register file. It owns the program counter and reads opcode1 and, when the instruction needs one, opcode2 from the combinational ROM one byte per cycle. It holds the assembled instruction under a valid/ready handshake until the execute side accepts it, and applies a taken jump by loading opcode2 into the PC.

---
 rtl/instr_fetch.sv | 113 +++++++++++
 tb/tb_instr_fetch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Two-byte instruction fetch: owns the PC, reads opcode1/opcode2 from a combinational ROM, applies taken jumps.
// Latency: 1-byte instruction valid 1 cycle after FETCH1 entry, 2-byte valid after 2; no prefetch, no back-to-back issue.
// Backpressure: opcode1/opcode2/fetch_pc/fetch_valid are held in ISSUE until fetch_ready; the PC does not advance meanwhile.
module instr_fetch (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_data,
  output logic [7:0] fetch_opcode1,
  output logic [7:0] fetch_opcode2,
  output logic [7:0] fetch_pc,
  output logic       fetch_valid,
  input  logic       fetch_ready,
  input  logic       fetch_jump
);

  localparam logic [1:0] ST_FETCH1 = 2'd0;
  localparam logic [1:0] ST_FETCH2 = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;

  localparam logic [3:0] OP_JUMP = 4'b0100;

  logic [1:0] state;
  logic [7:0] pc;
  logic [7:0] pc_inc;
  logic       first_is_two_byte;
  logic       jump_taken;

  // Opcode classes 0001..0100 and every 1xxx carry an operand byte;
  // nop and the undefined 0101..0111 are single-byte.
  function automatic logic needs_operand(input logic [3:0] op_hi);
    logic r;
    r = 1'b0;
    if (op_hi[3]) begin
      r = 1'b1;
    end else begin
      case (op_hi[2:0])
        3'b001, 3'b010, 3'b011, 3'b100: r = 1'b1;
        default:                        r = 1'b0;
      endcase
    end
    return r;
  endfunction

  // The ROM is addressed straight from the PC in every state; in ISSUE this
  // is simply the next fetch address and the ROM output is ignored.
  assign rom_address = pc;

  // Modulo-256 increment: 8'hFF rolls over to 8'h00, so a 2-byte
  // instruction at the top of memory takes its operand from address 0.
  assign pc_inc = pc + 8'd1;

  // Length decode of the byte currently presented by the ROM (used in FETCH1).
  assign first_is_two_byte = needs_operand(rom_data[7:4]);

  // A jump redirects only when the issued instruction is a jump and the
  // Controller's condition is true in the accept cycle.
  assign jump_taken = (fetch_opcode1[7:4] == OP_JUMP) && fetch_jump;

  // Fetch FSM, PC and the registered instruction outputs; reset overrides
  // everything including an in-progress handshake or jump.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_FETCH1;
      pc            <= 8'h00;
      fetch_opcode1 <= 8'h00;
      fetch_opcode2 <= 8'h00;
      fetch_pc      <= 8'h00;
      fetch_valid   <= 1'b0;
    end else begin
      case (state)
        ST_FETCH1: begin
          fetch_opcode1 <= rom_data;
          fetch_pc      <= pc;
          pc            <= pc_inc;
          if (first_is_two_byte) begin
            state <= ST_FETCH2;
          end else begin
            fetch_opcode2 <= 8'h00;
            fetch_valid   <= 1'b1;
            state         <= ST_ISSUE;
          end
        end

        ST_FETCH2: begin
          fetch_opcode2 <= rom_data;
          pc            <= pc_inc;
          fetch_valid   <= 1'b1;
          state         <= ST_ISSUE;
        end

        ST_ISSUE: begin
          // Hold everything until accepted; PC already points past the
          // instruction so the not-taken path leaves it alone.
          if (fetch_ready) begin
            fetch_valid <= 1'b0;
            state       <= ST_FETCH1;
            if (jump_taken) begin
              pc <= fetch_opcode2;
            end
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean fetch.
          fetch_valid <= 1'b0;
          state       <= ST_FETCH1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rom_address;
  logic [7:0] rom_data;
  logic [7:0] fetch_opcode1;
  logic [7:0] fetch_opcode2;
  logic [7:0] fetch_pc;
  logic       fetch_valid;
  logic       fetch_ready;
  logic       fetch_jump;

  logic [7:0] rom [256];
  logic [7:0] model_pc;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_address];

  instr_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .rom_address   (rom_address),
    .rom_data      (rom_data),
    .fetch_opcode1 (fetch_opcode1),
    .fetch_opcode2 (fetch_opcode2),
    .fetch_pc      (fetch_pc),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .fetch_jump    (fetch_jump)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction length straight from the opcode table, as byte ranges.
  function automatic int ref_len(input logic [7:0] op);
    if (op >= 8'h80) return 2;
    if (op >= 8'h10 && op < 8'h50) return 2;
    return 1;
  endfunction

  task automatic do_reset(input string tag);
    reset = 1'b1;
    fetch_ready = 1'b0;
    fetch_jump = 1'b0;
    tick();
    chk({tag, ".valid"}, {7'd0, fetch_valid}, 8'h00);
    chk({tag, ".op1"}, fetch_opcode1, 8'h00);
    chk({tag, ".op2"}, fetch_opcode2, 8'h00);
    chk({tag, ".pc"}, fetch_pc, 8'h00);
    chk({tag, ".addr"}, rom_address, 8'h00);
    reset = 1'b0;
    model_pc = 8'h00;
  endtask

  // Fetch, check and accept one instruction starting from FETCH1 at model_pc.
  task automatic run_instr(input string tag, input int hold, input logic jmp);
    logic [7:0] op1, op2, nxt;
    int len, n;
    op1 = rom[model_pc];
    len = ref_len(op1);
    nxt = model_pc + 8'd1;
    op2 = (len == 2) ? rom[nxt] : 8'h00;
    nxt = model_pc + 8'(len);
    n = 0;
    while (fetch_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, ".latency"}, 8'(n), 8'(len));
    chk({tag, ".op1"}, fetch_opcode1, op1);
    chk({tag, ".op2"}, fetch_opcode2, op2);
    chk({tag, ".pc"}, fetch_pc, model_pc);
    for (int h = 0; h < hold; h++) begin
      fetch_ready = 1'b0;
      fetch_jump = 1'($urandom_range(0, 1));
      tick();
      chk({tag, ".hold_valid"}, {7'd0, fetch_valid}, 8'h01);
      chk({tag, ".hold_op1"}, fetch_opcode1, op1);
      chk({tag, ".hold_op2"}, fetch_opcode2, op2);
      chk({tag, ".hold_pc"}, fetch_pc, model_pc);
      chk({tag, ".hold_addr"}, rom_address, nxt);
    end
    fetch_ready = 1'b1;
    fetch_jump = jmp;
    tick();
    fetch_ready = 1'b0;
    fetch_jump = 1'b0;
    if ((op1 >= 8'h40) && (op1 < 8'h50) && jmp) nxt = op2;
    chk({tag, ".post_valid"}, {7'd0, fetch_valid}, 8'h00);
    chk({tag, ".next_addr"}, rom_address, nxt);
    model_pc = nxt;
  endtask

  initial begin
    reset = 1'b1;
    fetch_ready = 1'b0;
    fetch_jump = 1'b0;
    model_pc = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h00;
    rom[8'h01] = 8'h2F;
    rom[8'h02] = 8'h01;
    rom[8'h03] = 8'h00;
    rom[8'h04] = 8'h40;
    rom[8'h05] = 8'h20;
    rom[8'h20] = 8'h40;
    rom[8'h21] = 8'h04;
    rom[8'h06] = 8'h80;
    rom[8'h07] = 8'h11;
    rom[8'h08] = 8'h55;
    rom[8'h09] = 8'h40;
    rom[8'h0A] = 8'hFF;
    rom[8'hFF] = 8'h13;

    do_reset("reset");
    run_instr("nop", 0, 1'b0);
    run_instr("load_bp", 5, 1'b0);
    run_instr("nop2", 0, 1'b0);
    run_instr("jump_taken", 0, 1'b1);
    run_instr("jump_self", 1, 1'b1);
    run_instr("jump_not_taken", 0, 1'b0);
    run_instr("alu_jump_ignored", 0, 1'b1);
    run_instr("undefined", 2, 1'b1);
    run_instr("jump_to_ff", 0, 1'b1);
    rom[8'h00] = 8'h7A;
    run_instr("wrap", 0, 1'b0);

    // Reset while in FETCH2.
    rom[8'h00] = 8'h2F;
    rom[8'h01] = 8'h99;
    do_reset("reset2");
    tick();
    chk("fetch2.addr", rom_address, 8'h01);
    reset = 1'b1;
    tick();
    chk("rst_fetch2.valid", {7'd0, fetch_valid}, 8'h00);
    chk("rst_fetch2.addr", rom_address, 8'h00);
    reset = 1'b0;
    model_pc = 8'h00;
    run_instr("after_rst_fetch2", 0, 1'b0);

    // Reset in ISSUE with a taken-jump handshake: reset wins.
    rom[8'h00] = 8'h40;
    rom[8'h01] = 8'h33;
    do_reset("reset3");
    tick();
    tick();
    chk("issue_jmp.valid", {7'd0, fetch_valid}, 8'h01);
    fetch_ready = 1'b1;
    fetch_jump = 1'b1;
    reset = 1'b1;
    tick();
    fetch_ready = 1'b0;
    fetch_jump = 1'b0;
    chk("rst_issue.valid", {7'd0, fetch_valid}, 8'h00);
    chk("rst_issue.addr", rom_address, 8'h00);
    chk("rst_issue.op1", fetch_opcode1, 8'h00);
    reset = 1'b0;
    model_pc = 8'h00;

    // Random program, random backpressure and jump conditions.
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    do_reset("reset_rnd");
    for (int k = 0; k < 150; k++) begin
      run_instr("rnd", int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
